// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - round-robin arbiter sharing one BRAM port between two requesters
// Macro BRAM_ARB_CLEAR_EN adds a zero-fill CLEAR walk after reset before RUN.
module bram_port_arbiter #(
   parameter int CORE            = 0,
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 8,
   parameter int SCAN_CYCLES_MIN = 0,
   parameter int SCAN_CYCLES_MAX = 1000
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    req0_read,
   input  logic                    req0_write,
   input  logic [DATA_WIDTH/8-1:0] req0_byteEnable,
   input  logic [ADDR_WIDTH-1:0]   req0_address,
   input  logic [DATA_WIDTH-1:0]   req0_writeData,
   output logic                    req0_ready,
   output logic [DATA_WIDTH-1:0]   req0_readData,
   output logic                    req0_valid,
   input  logic                    req1_read,
   input  logic                    req1_write,
   input  logic [DATA_WIDTH/8-1:0] req1_byteEnable,
   input  logic [ADDR_WIDTH-1:0]   req1_address,
   input  logic [DATA_WIDTH-1:0]   req1_writeData,
   output logic                    req1_ready,
   output logic [DATA_WIDTH-1:0]   req1_readData,
   output logic                    req1_valid,
   output logic                    bram_readEnable,
   output logic                    bram_writeEnable,
   output logic [DATA_WIDTH/8-1:0] bram_writeByteEnable,
   output logic [ADDR_WIDTH-1:0]   bram_address,
   output logic [DATA_WIDTH-1:0]   bram_writeData,
   input  logic [DATA_WIDTH-1:0]   bram_readData,
   output logic                    init_done,
   input  logic                    scan
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   state_t                  state_q, state_d;
   logic                    last_grant_q, last_grant_d;
   logic                    rsp_pend_q, rsp_pend_d;
   logic                    rsp_owner_q, rsp_owner_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
   logic signed [31:0]      cycle_q, cycle_d;

   logic                    pend0, pend1, grant0, grant1;
   logic                    sel_read, sel_write;
   logic [BE_WIDTH-1:0]     sel_be;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [DATA_WIDTH-1:0]   sel_data;

   always_comb begin
      pend0  = req0_read | req0_write;
      pend1  = req1_read | req1_write;
      grant0 = 1'b0;
      grant1 = 1'b0;
      // On conflict the requester that did not win the last accept goes first.
      if (!reset && state_q == ST_RUN) begin
         if (pend0 && pend1) begin
            grant0 = last_grant_q;
            grant1 = ~last_grant_q;
         end else begin
            grant0 = pend0;
            grant1 = pend1;
         end
      end

      sel_read  = grant1 ? req1_read       : req0_read;
      sel_write = grant1 ? req1_write      : req0_write;
      sel_be    = grant1 ? req1_byteEnable : req0_byteEnable;
      sel_addr  = grant1 ? req1_address    : req0_address;
      sel_data  = grant1 ? req1_writeData  : req0_writeData;

      bram_readEnable      = 1'b0;
      bram_writeEnable     = 1'b0;
      bram_writeByteEnable = '0;
      bram_address         = addr_q;
      bram_writeData       = wdata_q;
      state_d              = state_q;
      last_grant_d         = last_grant_q;
      rsp_pend_d           = 1'b0;
      rsp_owner_d          = rsp_owner_q;
      clr_addr_d           = clr_addr_q;
      cycle_d              = cycle_q + 1;

      if (grant0 || grant1) begin
         last_grant_d         = grant1;
         rsp_owner_d          = grant1;
         bram_address         = sel_addr;
         bram_writeData       = sel_data;
         bram_writeEnable     = sel_write;
         bram_readEnable      = sel_read & ~sel_write;
         bram_writeByteEnable = sel_write ? sel_be : '0;
         rsp_pend_d           = sel_read & ~sel_write;
      end

`ifdef BRAM_ARB_CLEAR_EN
      if (!reset && state_q == ST_CLEAR) begin
         bram_writeEnable     = 1'b1;
         bram_writeByteEnable = '1;
         bram_address         = clr_addr_q;
         bram_writeData       = '0;
         clr_addr_d           = clr_addr_q + 1'b1;
         if (&clr_addr_q) state_d = ST_RUN;
      end
`endif

      addr_d  = bram_address;
      wdata_d = bram_writeData;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
`ifdef BRAM_ARB_CLEAR_EN
         state_q <= ST_CLEAR;
`else
         state_q <= ST_RUN;
`endif
         last_grant_q <= 1'b1;
         rsp_pend_q   <= 1'b0;
         rsp_owner_q  <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         clr_addr_q   <= '0;
         cycle_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         rsp_pend_q   <= rsp_pend_d;
         rsp_owner_q  <= rsp_owner_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         clr_addr_q   <= clr_addr_d;
         cycle_q      <= cycle_d;
      end
   end

   // Reset masks the registered response so an in-flight read is dropped.
   assign req0_ready    = grant0;
   assign req1_ready    = grant1;
   assign req0_readData = bram_readData;
   assign req1_readData = bram_readData;
   assign req0_valid    = rsp_pend_q & ~rsp_owner_q & ~reset;
   assign req1_valid    = rsp_pend_q & rsp_owner_q & ~reset;
   assign init_done     = (state_q == ST_RUN) & ~reset;

`ifndef SYNTHESIS
   always @(negedge clock) begin
      if (scan && cycle_q >= SCAN_CYCLES_MIN && cycle_q <= SCAN_CYCLES_MAX)
         $display("core %0d cycle %0d state %s g0 %b g1 %b re %b we %b be %h addr %h wdata %h rdata %h",
                  CORE, cycle_q, state_q.name(), grant0, grant1, bram_readEnable, bram_writeEnable,
                  bram_writeByteEnable, bram_address, bram_writeData, bram_readData);
   end
`endif
endmodule
